// File: rtl/prog_mem_loader_if.sv
// Fetch bus and byte-stream loader bus of the reloadable PicoBlaze program store.
interface prog_mem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_abort;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [7:0]        checksum;

  modport master (
    output address, load_start, load_len, load_abort, rx_data, rx_valid,
    input  instruction, rx_ready, cpu_hold, load_busy, load_done, load_err, checksum
  );

  modport slave (
    input  address, load_start, load_len, load_abort, rx_data, rx_valid,
    output instruction, rx_ready, cpu_hold, load_busy, load_done, load_err, checksum
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Field-reloadable instruction store: registered read-first fetch port plus a
// byte-stream loader that holds the processor in reset while it rewrites memory.
module prog_mem_loader #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 18,
  parameter string INIT_FILE = ""
) (
  input logic clk,
  input logic rst_n,
  prog_mem_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BPW   = (DATA_W + 7) / 8;
  localparam int AW    = BPW * 8;
  localparam int CW    = $clog2(BPW + 1);
  localparam logic [CW-1:0]   LAST_B  = CW'(BPW - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CW-1:0]     r_byte_cnt;
  logic [AW-1:0]     r_asm;
  logic [7:0]        r_csum;
  logic              r_err;

  logic          w_len_ok, w_rx_ready, w_xfer, w_word_end, w_last, w_hold, w_done;
  logic [AW-1:0] w_asm_next;

  // Power-up contents only; rst_n never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  assign w_len_ok   = (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
  assign w_rx_ready = (r_state == S_LOAD) && !bus.load_abort;
  assign w_xfer     = w_rx_ready && bus.rx_valid;
  assign w_asm_next = (r_asm << 8) | AW'(bus.rx_data);
  assign w_word_end = w_xfer && (r_byte_cnt == LAST_B);
  assign w_last     = w_word_end && ({1'b0, r_wr_addr} == r_len - ONE_L);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_hold = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.load_start && w_len_ok) w_next = S_LOAD;
      S_LOAD: begin
        w_hold = 1'b1;
        if (bus.load_abort) w_next = S_IDLE;
        else if (w_last)    w_next = S_DONE;
      end
      S_DONE: begin
        w_hold = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_wr_addr  <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_csum     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE && bus.load_start) begin
        if (w_len_ok) begin
          r_len      <= bus.load_len;
          r_wr_addr  <= '0;
          r_byte_cnt <= '0;
          r_csum     <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_LOAD && bus.load_abort) r_err <= 1'b1;
      if (w_xfer) begin
        r_asm  <= w_asm_next;
        r_csum <= r_csum + bus.rx_data;
        if (w_word_end) begin
          r_byte_cnt <= '0;
          r_wr_addr  <= r_wr_addr + 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

  // Write and read in separate processes; the NBA read sees pre-write data.
  always_ff @(posedge clk) begin
    if (w_word_end) r_mem[r_wr_addr] <= w_asm_next[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_instr <= '0;
    else        r_instr <= r_mem[bus.address];
  end

  assign bus.instruction = r_instr;
  assign bus.rx_ready    = w_rx_ready;
  assign bus.cpu_hold    = w_hold;
  assign bus.load_busy   = w_hold;
  assign bus.load_done   = w_done;
  assign bus.load_err    = r_err;
  assign bus.checksum    = r_csum;
endmodule
